// File: rtl/ex_mdu.sv
// ============================================================================
//  Module   : ex_mdu
//  Purpose  : Iterative RV32M multiply/divide unit sitting beside the EX-stage
//             ALU. Radix-2: one multiplier bit or one quotient bit per cycle.
//             Requests a pipeline stall while busy and presents a registered
//             32-bit result with a one-cycle done pulse.
//  Ports    : clk        - rising-edge clock
//             reset      - synchronous, active-high reset
//             start      - M-extension op present in EX (sampled in IDLE)
//             MDUCode    - funct3 (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//             A, B       - rs1 / rs2 forwarded operands
//             flush      - squash the in-flight operation
//             stall_req  - combinational stall request for IF/ID/EX
//             done       - one-cycle pulse, MDUResult valid
//             MDUResult  - registered result, held until next completion
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mdu (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  MDUCode,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] MDUResult
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic        sa_q, sa_d;        // A was negative and treated as signed
  logic        sb_q, sb_d;        // B was negative and treated as signed
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;      // product register, or {remainder, quotient}
  logic [31:0] b_q, b_d;          // multiplicand magnitude, or divisor magnitude
  logic        done_q, done_d;
  logic [31:0] res_q, res_d;

  // ---------------- operand decode at acceptance ----------------
  logic        w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic [31:0] w_mag_a, w_mag_b;
  logic        w_b_zero, w_ovf, w_special;
  logic [31:0] w_special_res;

  always_comb begin
    w_sgn_a  = (MDUCode == 3'b001) | (MDUCode == 3'b010) |
               (MDUCode == 3'b100) | (MDUCode == 3'b110);
    w_sgn_b  = (MDUCode == 3'b001) | (MDUCode == 3'b100) | (MDUCode == 3'b110);
    w_neg_a  = w_sgn_a & A[31];
    w_neg_b  = w_sgn_b & B[31];
    w_mag_a  = w_neg_a ? (32'd0 - A) : A;
    w_mag_b  = w_neg_b ? (32'd0 - B) : B;
    w_b_zero = (B == 32'd0);
    w_ovf    = ((MDUCode == 3'b100) | (MDUCode == 3'b110)) &
               (A == 32'h8000_0000) & (B == 32'hFFFF_FFFF);
    w_special = (MDUCode[2] & w_b_zero) | w_ovf;
    // MDUCode[1] distinguishes REM* from DIV* within the divide group.
    if (w_b_zero)
      w_special_res = MDUCode[1] ? A : 32'hFFFF_FFFF;
    else
      w_special_res = MDUCode[1] ? 32'd0 : 32'h8000_0000;
  end

  // ---------------- one iteration step ----------------
  logic [32:0] w_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_rem_sh;
  logic        w_ge;
  logic [31:0] w_rem_new;
  logic [63:0] w_div_next;
  logic [63:0] w_step;

  always_comb begin
    // Shift-add: multiplier sits in the low half and is consumed LSB first.
    w_sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    w_mul_next = {w_sum, acc_q[31:1]};
    // Restoring divide: remainder is always below the divisor, so the shifted
    // value fits in 33 bits and the difference (when kept) fits in 32.
    w_rem_sh   = acc_q[63:31];
    w_ge       = (w_rem_sh >= {1'b0, b_q});
    w_rem_new  = w_ge ? (w_rem_sh[31:0] - b_q) : w_rem_sh[31:0];
    w_div_next = {w_rem_new, acc_q[30:0], w_ge};
    w_step     = op_q[2] ? w_div_next : w_mul_next;
  end

  // ---------------- sign fix of the final step ----------------
  logic [63:0] w_prod_fix;
  logic [31:0] w_quot_fix, w_rem_fix, w_fix;

  always_comb begin
    // MUL and MULHU latch both signs as 0; MULHSU latches sb as 0.
    w_prod_fix = (sa_q ^ sb_q) ? (64'd0 - w_step) : w_step;
    w_quot_fix = (sa_q ^ sb_q) ? (32'd0 - w_step[31:0])  : w_step[31:0];
    w_rem_fix  = sa_q          ? (32'd0 - w_step[63:32]) : w_step[63:32];
    if (op_q[2])
      w_fix = op_q[1] ? w_rem_fix : w_quot_fix;
    else
      w_fix = (op_q[1:0] == 2'b00) ? w_prod_fix[31:0] : w_prod_fix[63:32];
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = w_special ? S_FINISH : S_RUN;
      S_RUN:   if (cnt_q == 5'd0) state_d = S_FINISH;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    stall_req = ~reset & (((state_q == S_IDLE) & start & ~flush) |
                          (state_q == S_RUN));
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    op_d   = op_q;
    sa_d   = sa_q;
    sb_d   = sb_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    b_d    = b_q;
    done_d = 1'b0;
    res_d  = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = MDUCode;
          sa_d  = w_neg_a;
          sb_d  = w_neg_b;
          cnt_d = 5'd31;
          if (MDUCode[2]) begin
            acc_d = {32'd0, w_mag_a};
            b_d   = w_mag_b;
          end else begin
            acc_d = {32'd0, w_mag_b};
            b_d   = w_mag_a;
          end
          if (w_special) begin
            res_d  = w_special_res;
            done_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        acc_d = w_step;
        if (cnt_q == 5'd0) begin
          res_d  = w_fix;
          done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      default: ;
    endcase
    // A squashed op never completes and never disturbs the visible result.
    if (flush) begin
      done_d = 1'b0;
      res_d  = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q   <= 3'd0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt_q  <= 5'd0;
      acc_q  <= 64'd0;
      b_q    <= 32'd0;
      done_q <= 1'b0;
      res_q  <= 32'd0;
    end else begin
      op_q   <= op_d;
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      b_q    <= b_d;
      done_q <= done_d;
      res_q  <= res_d;
    end
  end

  assign done      = done_q;
  assign MDUResult = res_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mdu.sv
// ============================================================================
//  Module   : tb_ex_mdu
//  Purpose  : Self-checking bench for ex_mdu against an arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDUCode;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  wire         stall_req;
  wire         done;
  wire  [31:0] MDUResult;

  int checks = 0;
  int errors = 0;

  ex_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .MDUCode   (MDUCode),
    .A         (A),
    .B         (B),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .MDUResult (MDUResult)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sx, sy, sp;
    logic        [63:0] up;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    ref_result = 32'd0;
    case (op)
      3'd0: begin up = {32'd0, a} * {32'd0, b}; ref_result = up[31:0]; end
      3'd1: begin sx = {{32{a[31]}}, a}; sy = {{32{b[31]}}, b}; sp = sx * sy; ref_result = sp[63:32]; end
      3'd2: begin sx = {{32{a[31]}}, a}; sy = {32'd0, b}; sp = sx * sy; ref_result = sp[63:32]; end
      3'd3: begin up = {32'd0, a} * {32'd0, b}; ref_result = up[63:32]; end
      3'd4: begin
        if (b == 0) ref_result = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'h8000_0000;
        else ref_result = sa / sb;
      end
      3'd5: ref_result = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) ref_result = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_result = 32'd0;
        else ref_result = sa % sb;
      end
      default: ref_result = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       pick_operand = 32'd0;
      1:       pick_operand = 32'hFFFF_FFFF;
      2:       pick_operand = 32'h8000_0000;
      3:       pick_operand = {27'd0, r[4:0]};
      default: pick_operand = r;
    endcase
  endfunction

  // Issues one op at the current (negedge) point and observes it; no checks.
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output bit stall_ok,
                          output logic stall_at_done, output logic done_after);
    logic [31:0] r;
    start = 1'b1; MDUCode = op; A = a; B = b;
    #1;
    stall_ok = (stall_req === 1'b1);
    @(negedge clk);
    r = $urandom;
    start = 1'b0; A = $urandom; B = $urandom; MDUCode = r[2:0];
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      if (stall_req !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    res = MDUResult;
    stall_at_done = stall_req;
    @(negedge clk);
    done_after = done;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; MDUCode = 3'd0; A = 32'd0; B = 32'd0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b need 0", done); end
    checks++; if (MDUResult !== 32'd0) begin errors++; $display("FAIL reset_result got %h need 0", MDUResult); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset_stall got %b need 0", stall_req); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (stall_req !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got stall=%b done=%b need 0/0", stall_req, done);
    end
  endtask

  task automatic test_directed();
    logic [2:0]  ops [12] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] as  [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exs [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                              32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    int          lats[12] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    int          lat;
    bit          sok;
    logic        sdone, dafter;
    for (int i = 0; i < 12; i++) begin
      drive_op(ops[i], as[i], bs[i], res, lat, sok, sdone, dafter);
      checks++; if (res !== exs[i]) begin errors++; $display("FAIL dir%0d_result got %h need %h", i, res, exs[i]); end
      checks++; if (lat != lats[i]) begin errors++; $display("FAIL dir%0d_latency got %0d need %0d", i, lat, lats[i]); end
      checks++; if (!sok) begin errors++; $display("FAIL dir%0d_stall got low while busy need high", i); end
      checks++; if (sdone !== 1'b0) begin errors++; $display("FAIL dir%0d_stall_at_done got %b need 0", i, sdone); end
      checks++; if (dafter !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got %b need 0", i, dafter); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, r, res, exp;
    logic [2:0]  op;
    int          lat;
    bit          sok;
    logic        sdone, dafter;
    for (int i = 0; i < 40; i++) begin
      r = $urandom; op = r[2:0];
      a = pick_operand(); b = pick_operand();
      exp = ref_result(op, a, b);
      drive_op(op, a, b, res, lat, sok, sdone, dafter);
      checks++; if (res !== exp) begin errors++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got %h need %h", i, op, a, b, res, exp); end
      checks++; if (lat != ref_latency(op, a, b)) begin errors++; $display("FAIL rnd%0d_latency got %0d need %0d", i, lat, ref_latency(op, a, b)); end
      checks++; if (!sok || dafter !== 1'b0) begin errors++; $display("FAIL rnd%0d_handshake got stall_ok=%b done_after=%b need 1/0", i, sok, dafter); end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res, a, b;
    int          lat;
    bit          sok, seen;
    logic        sdone, dafter;
    drive_op(3'd0, 32'd3, 32'd5, res, lat, sok, sdone, dafter);
    checks++; if (res !== 32'd15) begin errors++; $display("FAIL flush_setup got %h need 0000000f", res); end
    // DIV in flight, squashed during cycle T+10
    start = 1'b1; MDUCode = 3'd4; A = $urandom; B = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL flush_stall got %b need 0", stall_req); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_done got %b need 0", done); end
    checks++; if (MDUResult !== 32'd15) begin errors++; $display("FAIL flush_result got %h need 0000000f", MDUResult); end
    a = $urandom; b = $urandom;
    drive_op(3'd0, a, b, res, lat, sok, sdone, dafter);
    checks++; if (lat != 33) begin errors++; $display("FAIL flush_next_latency got %0d need 33", lat); end
    checks++; if (res !== ref_result(3'd0, a, b)) begin errors++; $display("FAIL flush_next_result got %h need %h", res, ref_result(3'd0, a, b)); end
    // start and flush together in IDLE: not accepted
    start = 1'b1; flush = 1'b1; MDUCode = 3'd5; A = 32'd9; B = 32'd0;
    #1;
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL startflush_stall got %b need 0", stall_req); end
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      if (done === 1'b1 || stall_req !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (seen) begin errors++; $display("FAIL startflush_accept got activity need none"); end
    checks++; if (MDUResult !== ref_result(3'd0, a, b)) begin errors++; $display("FAIL startflush_result got %h need %h", MDUResult, ref_result(3'd0, a, b)); end
  endtask

  task automatic test_reset_mid();
    bit seen;
    start = 1'b1; MDUCode = 3'd3; A = $urandom; B = $urandom;
    @(negedge clk);
    A = $urandom; B = $urandom;      // start stays high during RUN
    repeat (4) @(negedge clk);
    reset = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done got %b need 0", done); end
    checks++; if (MDUResult !== 32'd0) begin errors++; $display("FAIL rstmid_result got %h need 0", MDUResult); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %b need 0", stall_req); end
    reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || stall_req !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_idle got activity need none"); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int          first, second, count, k;
    bit          data_ok;
    a = $urandom; b = $urandom;
    first = -1; second = -1; count = 0; data_ok = 1'b1;
    start = 1'b1; MDUCode = 3'd0; A = a; B = b;
    for (k = 0; k <= 70; k++) begin
      if (done === 1'b1) begin
        count++;
        if (first < 0) first = k; else if (second < 0) second = k;
        if (MDUResult !== ref_result(3'd0, a, b)) data_ok = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (first != 33) begin errors++; $display("FAIL b2b_first got %0d need 33", first); end
    checks++; if (second != 67) begin errors++; $display("FAIL b2b_second got %0d need 67", second); end
    checks++; if (count != 2) begin errors++; $display("FAIL b2b_count got %0d need 2", count); end
    checks++; if (!data_ok) begin errors++; $display("FAIL b2b_result got wrong data need %h", ref_result(3'd0, a, b)); end
    k = 0;
    while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    checks++; if (k >= 40) begin errors++; $display("FAIL b2b_drain got timeout need done"); end
    @(negedge clk);
    // special-case back-to-back: one op every two cycles
    first = -1; count = 0; data_ok = 1'b1;
    start = 1'b1; MDUCode = 3'd5; A = 32'd77; B = 32'd0;
    for (k = 0; k <= 5; k++) begin
      if (done === 1'b1) begin
        count++;
        if (first < 0) first = k;
        if (MDUResult !== 32'hFFFF_FFFF) data_ok = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (first != 1 || count != 3) begin errors++; $display("FAIL b2b_special got first=%0d count=%0d need 1/3", first, count); end
    checks++; if (!data_ok) begin errors++; $display("FAIL b2b_special_result got wrong data need ffffffff"); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
